// File: rtl/traffic_pkg.sv
// Shared state encoding, lamp codes and phase-timer sizing for the crossing
// controller and the lamp drivers that share its buses.
package traffic_pkg;

  localparam int TMR_W = 5;

  typedef enum logic [2:0] {
    GREEN     = 3'd0,
    YELLOW    = 3'd1,
    ALLRED1   = 3'd2,
    WALK      = 3'd3,
    PED_CLEAR = 3'd4,
    ALLRED2   = 3'd5,
    FLASH     = 3'd6
  } state_t;

  localparam logic [2:0] TRAF_RED    = 3'b001;
  localparam logic [2:0] TRAF_YELLOW = 3'b010;
  localparam logic [2:0] TRAF_GREEN  = 3'b100;
  localparam logic [2:0] TRAF_DARK   = 3'b000;

  localparam logic [1:0] PED_GREEN = 2'b01;
  localparam logic [1:0] PED_RED   = 2'b10;
  localparam logic [1:0] PED_DARK  = 2'b00;

  function automatic logic t_legal(input int t);
    return (t >= 1) && (t <= 31);
  endfunction

  // A phase of T ticks loads T-1 and leaves when the count reaches zero.
  function automatic logic [TMR_W-1:0] tmr_ld(input int t);
    return TMR_W'(t - 1);
  endfunction

endpackage

// File: rtl/crossing_controller_if.sv
// Push-button / maintenance inputs and lamp outputs of the crossing controller.
interface crossing_controller_if;
  logic       ped_req;
  logic       flash_en;
  logic [2:0] traf_state;
  logic [1:0] ped_state;
  logic       req_pending;

  modport master (output ped_req, flash_en, input traf_state, ped_state, req_pending);
  modport slave  (input ped_req, flash_en, output traf_state, ped_state, req_pending);
endinterface

// File: rtl/phase_timer.sv
// Loadable down-counter timing each phase; saturates at zero.
module phase_timer
  import traffic_pkg::*;
#(
  parameter logic [TMR_W-1:0] RST_VAL = '0
) (
  input  logic             clk_1Hz,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             zero
);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n)          cnt <= RST_VAL;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/crossing_controller.sv
// Demand-actuated mid-block pedestrian crossing: minimum green, request latch,
// stop/walk/clearance sequence and a maintenance flashing mode.
module crossing_controller
  import traffic_pkg::*;
#(
  parameter int T_MIN_GREEN = 10,
  parameter int T_YELLOW    = 2,
  parameter int T_ALLRED    = 1,
  parameter int T_WALK      = 8,
  parameter int T_CLEAR     = 4
) (
  input  logic                 clk_1Hz,
  input  logic                 rst_n,
  crossing_controller_if.slave bus
);

  localparam logic [TMR_W-1:0] LD_GREEN  = tmr_ld(T_MIN_GREEN);
  localparam logic [TMR_W-1:0] LD_YELLOW = tmr_ld(T_YELLOW);
  localparam logic [TMR_W-1:0] LD_ALLRED = tmr_ld(T_ALLRED);
  localparam logic [TMR_W-1:0] LD_WALK   = tmr_ld(T_WALK);
  localparam logic [TMR_W-1:0] LD_CLEAR  = tmr_ld(T_CLEAR);
  localparam bit T_OK = t_legal(T_MIN_GREEN) && t_legal(T_YELLOW) && t_legal(T_ALLRED)
                     && t_legal(T_WALK) && t_legal(T_CLEAR);

  state_t           state, nxt;
  logic             req_pending, blink;
  logic             ld, tmr_zero;
  logic [TMR_W-1:0] ld_val;
  logic [2:0]       traf;
  logic [1:0]       ped;

  phase_timer #(.RST_VAL(LD_ALLRED)) u_timer (
    .clk_1Hz  (clk_1Hz),
    .rst_n    (rst_n),
    .load     (ld),
    .load_val (ld_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    nxt    = state;
    ld     = 1'b0;
    ld_val = '0;
    case (state)
      GREEN:     if (tmr_zero && (bus.flash_en || req_pending)) begin
                   nxt = YELLOW;    ld = 1'b1; ld_val = LD_YELLOW;
                 end
      YELLOW:    if (tmr_zero) begin nxt = ALLRED1; ld = 1'b1; ld_val = LD_ALLRED; end
      ALLRED1:   if (tmr_zero) begin
                   // Maintenance takes priority over a waiting pedestrian.
                   if (bus.flash_en) nxt = FLASH;
                   else begin nxt = WALK; ld = 1'b1; ld_val = LD_WALK; end
                 end
      WALK:      if (tmr_zero) begin nxt = PED_CLEAR; ld = 1'b1; ld_val = LD_CLEAR; end
      PED_CLEAR: if (tmr_zero) begin nxt = ALLRED2;   ld = 1'b1; ld_val = LD_ALLRED; end
      ALLRED2:   if (tmr_zero) begin nxt = GREEN;     ld = 1'b1; ld_val = LD_GREEN; end
      FLASH:     if (!bus.flash_en) begin nxt = ALLRED2; ld = 1'b1; ld_val = LD_ALLRED; end
      default:   begin nxt = ALLRED2; ld = 1'b1; ld_val = LD_ALLRED; end
    endcase
  end

  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ALLRED2;
      req_pending <= 1'b0;
      blink       <= 1'b1;
    end else begin
      state <= nxt;
      // Entering WALK serves the request; a press on that same edge is absorbed.
      if (state == FLASH || (state == ALLRED1 && nxt == WALK))
        req_pending <= 1'b0;
      else if (state != WALK && bus.ped_req)
        req_pending <= 1'b1;
      if ((nxt == PED_CLEAR || nxt == FLASH) && nxt != state)
        blink <= 1'b1;
      else if (state == PED_CLEAR || state == FLASH)
        blink <= ~blink;
    end
  end

  always_comb begin
    traf = TRAF_RED;
    ped  = PED_RED;
    case (state)
      GREEN:     traf = TRAF_GREEN;
      YELLOW:    traf = TRAF_YELLOW;
      WALK:      ped  = PED_GREEN;
      PED_CLEAR: ped  = blink ? PED_RED : PED_DARK;
      FLASH:     begin traf = blink ? TRAF_YELLOW : TRAF_DARK; ped = PED_DARK; end
      default:   ;
    endcase
  end

  assign bus.traf_state  = traf;
  assign bus.ped_state   = ped;
  assign bus.req_pending = req_pending;

  param_range_chk: assert property (@(posedge clk_1Hz) T_OK)
    else $error("crossing_controller: timing parameter outside 1..31");

endmodule

// File: tb/tb_crossing_controller.sv
// Bench for crossing_controller: directed scenarios plus random button/flash
// traffic, checked against a phase/age reference model.
module tb_crossing_controller;

  localparam int TG = 10, TY = 2, TA = 1, TW = 8, TC = 4;
  localparam int P_GREEN = 0, P_YEL = 1, P_AR1 = 2, P_WALK = 3, P_CLR = 4, P_AR2 = 5, P_FLASH = 6;

  logic clk_1Hz = 1'b0;
  logic rst_n   = 1'b1;
  crossing_controller_if bus();

  crossing_controller #(
    .T_MIN_GREEN(TG), .T_YELLOW(TY), .T_ALLRED(TA), .T_WALK(TW), .T_CLEAR(TC)
  ) dut (
    .clk_1Hz (clk_1Hz),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  int n_chk = 0, n_err = 0;
  int e;                  // index of the last edge taken since reset release
  int m_ph, m_age;        // model phase and edges spent in it since entry
  bit m_pend;

  function automatic logic [2:0] exp_traf();
    case (m_ph)
      P_GREEN: return 3'b100;
      P_YEL:   return 3'b010;
      P_FLASH: return (m_age % 2 == 0) ? 3'b010 : 3'b000;
      default: return 3'b001;
    endcase
  endfunction

  function automatic logic [1:0] exp_ped();
    case (m_ph)
      P_WALK:  return 2'b01;
      P_CLR:   return (m_age % 2 == 0) ? 2'b10 : 2'b00;
      P_FLASH: return 2'b00;
      default: return 2'b10;
    endcase
  endfunction

  task automatic model_step(input logic req, input logic fl);
    int nph;
    nph = m_ph;
    case (m_ph)
      P_GREEN: if (m_age >= TG - 1 && (fl || m_pend)) nph = P_YEL;
      P_YEL:   if (m_age == TY - 1) nph = P_AR1;
      P_AR1:   if (m_age == TA - 1) nph = fl ? P_FLASH : P_WALK;
      P_WALK:  if (m_age == TW - 1) nph = P_CLR;
      P_CLR:   if (m_age == TC - 1) nph = P_AR2;
      P_AR2:   if (m_age == TA - 1) nph = P_GREEN;
      default: if (!fl) nph = P_AR2;
    endcase
    if (m_ph == P_FLASH || (nph == P_WALK && m_ph != P_WALK)) m_pend = 1'b0;
    else if (m_ph != P_WALK && req)                           m_pend = 1'b1;
    m_age = (nph != m_ph) ? 0 : m_age + 1;
    m_ph  = nph;
  endtask

  task automatic tick(input logic req, input logic fl);
    bus.ped_req  = req;
    bus.flash_en = fl;
    @(posedge clk_1Hz);
    model_step(req, fl);
    e++;
    #1;
  endtask

  task automatic do_reset();
    bus.ped_req  = 1'b0;
    bus.flash_en = 1'b0;
    rst_n = 1'b0;
    @(posedge clk_1Hz);
    #3;
    m_ph = P_AR2; m_age = 0; m_pend = 1'b0;
    rst_n = 1'b1;
    e = -1;
  endtask

  task automatic test_reset();
    bus.ped_req  = 1'b0;
    bus.flash_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.traf_state !== 3'b001 || bus.ped_state !== 2'b10 || bus.req_pending !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async got %b/%b/%b want 001/10/0", bus.traf_state, bus.ped_state, bus.req_pending);
    end
    @(posedge clk_1Hz);
    #3;
    m_ph = P_AR2; m_age = 0; m_pend = 1'b0;
    rst_n = 1'b1;
    e = -1;
    #1;
    n_chk++;
    if (bus.traf_state !== 3'b001 || bus.ped_state !== 2'b10) begin
      n_err++;
      $display("FAIL reset_release got %b/%b want 001/10", bus.traf_state, bus.ped_state);
    end
    tick(1'b0, 1'b0);
    n_chk++;
    if (bus.traf_state !== 3'b100 || bus.ped_state !== 2'b10 || bus.req_pending !== 1'b0) begin
      n_err++;
      $display("FAIL first_green got %b/%b/%b want 100/10/0", bus.traf_state, bus.ped_state, bus.req_pending);
    end
  endtask

  task automatic test_idle();
    do_reset();
    for (int i = 0; i <= 100; i++) begin
      tick(1'b0, 1'b0);
      n_chk++;
      if (bus.traf_state !== exp_traf() || bus.ped_state !== exp_ped() || bus.req_pending !== m_pend) begin
        n_err++;
        $display("FAIL idle e=%0d got %b/%b/%b want %b/%b/%b", e, bus.traf_state, bus.ped_state,
                 bus.req_pending, exp_traf(), exp_ped(), m_pend);
      end
    end
    n_chk++;
    if (bus.traf_state !== 3'b100 || bus.req_pending !== 1'b0) begin
      n_err++;
      $display("FAIL idle_hold got %b/%b want 100/0", bus.traf_state, bus.req_pending);
    end
  endtask

  task automatic test_single_request();
    logic [2:0] xt; logic [1:0] xp; bit chk;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      tick(i == 3, 1'b0);
      n_chk++;
      if (bus.traf_state !== exp_traf() || bus.ped_state !== exp_ped() || bus.req_pending !== m_pend) begin
        n_err++;
        $display("FAIL single_model e=%0d got %b/%b/%b want %b/%b/%b", e, bus.traf_state, bus.ped_state,
                 bus.req_pending, exp_traf(), exp_ped(), m_pend);
      end
      chk = 1'b1; xt = 3'b001; xp = 2'b10;
      case (e)
        9:  xt = 3'b100;
        10: xt = 3'b010;
        12: ;
        13: xp = 2'b01;
        21: ;
        22: xp = 2'b00;
        23: ;
        24: xp = 2'b00;
        25: ;
        26: xt = 3'b100;
        default: chk = 1'b0;
      endcase
      if (chk) begin
        n_chk++;
        if (bus.traf_state !== xt || bus.ped_state !== xp) begin
          n_err++;
          $display("FAIL single_seq e=%0d got %b/%b want %b/%b", e, bus.traf_state, bus.ped_state, xt, xp);
        end
      end
      if (e == 3 || e == 13) begin
        n_chk++;
        if (bus.req_pending !== (e == 3)) begin
          n_err++;
          $display("FAIL single_pend e=%0d got %b want %b", e, bus.req_pending, e == 3);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 45; i++) begin
      tick((i >= 3 && i <= 14) || i == 24, 1'b0);
      n_chk++;
      if (bus.traf_state !== exp_traf() || bus.ped_state !== exp_ped() || bus.req_pending !== m_pend) begin
        n_err++;
        $display("FAIL simul_model e=%0d got %b/%b/%b want %b/%b/%b", e, bus.traf_state, bus.ped_state,
                 bus.req_pending, exp_traf(), exp_ped(), m_pend);
      end
      if (e == 13 || e == 14) begin
        n_chk++;
        if (bus.req_pending !== 1'b0 || bus.ped_state !== 2'b01) begin
          n_err++;
          $display("FAIL clear_wins e=%0d got pend=%b ped=%b want 0/01", e, bus.req_pending, bus.ped_state);
        end
      end
      if (e == 26) begin
        n_chk++;
        if (bus.req_pending !== 1'b1 || bus.traf_state !== 3'b100) begin
          n_err++;
          $display("FAIL carry_req got pend=%b traf=%b want 1/100", bus.req_pending, bus.traf_state);
        end
      end
      if (e == 38 || e == 39) begin
        n_chk++;
        if (bus.ped_state !== ((e == 39) ? 2'b01 : 2'b10)) begin
          n_err++;
          $display("FAIL second_walk e=%0d got %b want %b", e, bus.ped_state, (e == 39) ? 2'b01 : 2'b10);
        end
      end
    end
  endtask

  task automatic test_flash();
    logic [2:0] xt; logic [1:0] xp; bit chk;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      tick(i == 20, i >= 5 && i < 30);
      n_chk++;
      if (bus.traf_state !== exp_traf() || bus.ped_state !== exp_ped() || bus.req_pending !== m_pend) begin
        n_err++;
        $display("FAIL flash_model e=%0d got %b/%b/%b want %b/%b/%b", e, bus.traf_state, bus.ped_state,
                 bus.req_pending, exp_traf(), exp_ped(), m_pend);
      end
      chk = 1'b1;
      case (e)
        9:  begin xt = 3'b100; xp = 2'b10; end
        10: begin xt = 3'b010; xp = 2'b10; end
        12: begin xt = 3'b001; xp = 2'b10; end
        13: begin xt = 3'b010; xp = 2'b00; end
        14: begin xt = 3'b000; xp = 2'b00; end
        15: begin xt = 3'b010; xp = 2'b00; end
        29: begin xt = 3'b010; xp = 2'b00; end
        30: begin xt = 3'b001; xp = 2'b10; end
        31: begin xt = 3'b100; xp = 2'b10; end
        default: begin chk = 1'b0; xt = 3'b000; xp = 2'b00; end
      endcase
      if (chk) begin
        n_chk++;
        if (bus.traf_state !== xt || bus.ped_state !== xp) begin
          n_err++;
          $display("FAIL flash_seq e=%0d got %b/%b want %b/%b", e, bus.traf_state, bus.ped_state, xt, xp);
        end
      end
      if (e == 20 || e == 21) begin
        n_chk++;
        if (bus.req_pending !== 1'b0) begin
          n_err++;
          $display("FAIL flash_ignores_req e=%0d got %b want 0", e, bus.req_pending);
        end
      end
    end
  endtask

  task automatic test_random();
    logic fl, rq;
    fl = 1'b0;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) fl = ~fl;
      rq = ($urandom_range(0, 7) == 0);
      tick(rq, fl);
      n_chk++;
      if (bus.traf_state !== exp_traf() || bus.ped_state !== exp_ped() || bus.req_pending !== m_pend) begin
        n_err++;
        $display("FAIL random e=%0d req=%b fl=%b got %b/%b/%b want %b/%b/%b", e, rq, fl, bus.traf_state,
                 bus.ped_state, bus.req_pending, exp_traf(), exp_ped(), m_pend);
      end
    end
  endtask

  task automatic test_reset_mid_walk();
    do_reset();
    for (int i = 0; i <= 18; i++) tick(i == 3, 1'b0);
    n_chk++;
    if (bus.ped_state !== 2'b01 || bus.traf_state !== 3'b001) begin
      n_err++;
      $display("FAIL pre_reset_walk got %b/%b want 001/01", bus.traf_state, bus.ped_state);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.traf_state !== 3'b001 || bus.ped_state !== 2'b10 || bus.req_pending !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_walk got %b/%b/%b want 001/10/0", bus.traf_state, bus.ped_state, bus.req_pending);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    bus.ped_req  = 1'b0;
    bus.flash_en = 1'b0;
    test_reset();
    test_idle();
    test_single_request();
    test_simultaneous();
    test_flash();
    test_random();
    test_reset_mid_walk();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
